// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the note player.
//   state_t      - FSM states (IDLE, PLAY, GAP)
//   NOTE_REST    - note code meaning silence
//   PITCH_HALF   - square-wave half-periods in clk cycles at 100 kHz, codes 1..12 (C..B, octave 4)
//   pitch_half() - table lookup returning 0 for any rest code (0, 13..15)
package note_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'd0;

    localparam logic [7:0] PITCH_HALF [12] = '{
        8'd191, 8'd180, 8'd170, 8'd161, 8'd152, 8'd143,
        8'd135, 8'd128, 8'd120, 8'd114, 8'd107, 8'd101
    };

    function automatic logic [7:0] pitch_half(input logic [3:0] code);
        if (code == NOTE_REST || code > 4'd12) begin
            return 8'd0;
        end
        return PITCH_HALF[code - 4'd1];
    endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: loadable millisecond countdown shared by the PLAY and GAP phases.
//   clk, rst_n  - clock, synchronous active-low reset
//   load_i      - start a new countdown of ms_count_i milliseconds
//   tpm_i       - clk cycles per millisecond (must be non-zero); also used
//                 to reload the prescaler at each millisecond boundary
//   ms_count_i  - number of milliseconds to count
//   done_o      - high while the final millisecond is in progress
//   tick_o      - one-cycle pulse on the last cycle of each millisecond
// The countdown is idle once the ms counter reaches zero; the last cycle of
// the whole interval is tick_o & done_o.
module ms_timer #(
    parameter int DUR_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [15:0]      tpm_i,
    input  logic [DUR_W-1:0] ms_count_i,
    output logic             done_o,
    output logic             tick_o
);

    logic [15:0]      pre_q, pre_d;
    logic [DUR_W-1:0] ms_q,  ms_d;

    assign tick_o = (ms_q != '0) && (pre_q == 16'd0);
    assign done_o = (ms_q == DUR_W'(1));

    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if (load_i) begin
            pre_d = tpm_i - 16'd1;
            ms_d  = ms_count_i;
        end else if (tick_o) begin
            pre_d = tpm_i - 16'd1;
            ms_d  = ms_q - DUR_W'(1);
        end else if (ms_q != '0) begin
            pre_d = pre_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= 16'd0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/note_player.sv
// note_player: plays one requested note as a square wave on the speaker pin,
// followed by a silent articulation gap, then accepts the next request.
//   clk, rst_n       - clock (100 kHz nominal), synchronous active-low reset
//   ticks_per_milli  - clk cycles per ms, sampled at acceptance (0 acts as 1)
//   note_valid/ready - request handshake; ready is registered
//   note_code        - 0 or 13..15 rest, 1..12 = C..B
//   note_octave      - octave shift above octave 4
//   note_dur_ms      - note length in ms (0 skips straight to the gap)
//   sound            - square-wave speaker drive
//   busy             - high while playing or in the gap
//   led              - {busy, sound, octave, code} of the current note, 0 when idle
module note_player
    import note_pkg::*;
#(
    parameter int GAP_MS = 10,
    parameter int DUR_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ticks_per_milli,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_code,
    input  logic [1:0]       note_octave,
    input  logic [DUR_W-1:0] note_dur_ms,
    output logic             sound,
    output logic             busy,
    output logic [7:0]       led
);

    localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);
    localparam bit               HAS_GAP = (GAP_MS != 0);

    state_t           state_q, state_d;
    logic             ready_q;
    logic             accept;
    logic [15:0]      tpm_in, tpm_q, tpm_sel;
    logic [7:0]       half_in, half_q;
    logic [7:0]       tone_cnt_q, tone_cnt_d;
    logic             sound_q, sound_d;
    logic [3:0]       code_q;
    logic [1:0]       oct_q;
    logic             load_play, load_gap, ms_load;
    logic [DUR_W-1:0] ms_count;
    logic             ms_done, ms_tick, ms_end;

    assign accept  = note_valid && ready_q;
    assign tpm_in  = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    // At acceptance the latched rate is not yet valid, so feed the live one.
    assign tpm_sel = accept ? tpm_in : tpm_q;
    assign half_in = pitch_half(note_code) >> note_octave;

    // Last cycle of the interval currently being timed.
    assign ms_end    = ms_tick && ms_done;
    assign load_play = accept && (note_dur_ms != '0);
    assign load_gap  = HAS_GAP && ((accept && (note_dur_ms == '0)) ||
                                   ((state_q == PLAY) && ms_end));
    assign ms_load   = load_play || load_gap;
    assign ms_count  = load_play ? note_dur_ms : GAP_LEN;

    ms_timer #(
        .DUR_W(DUR_W)
    ) u_ms_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ms_load),
        .tpm_i     (tpm_sel),
        .ms_count_i(ms_count),
        .done_o    (ms_done),
        .tick_o    (ms_tick)
    );

    // State register; ready is high in every IDLE cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (note_dur_ms != '0) begin
                        state_d = PLAY;
                    end else if (HAS_GAP) begin
                        state_d = GAP;
                    end
                end
            end
            PLAY:    if (ms_end) state_d = HAS_GAP ? GAP : IDLE;
            GAP:     if (ms_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        sound      = sound_q;
        note_ready = ready_q;
        led        = (state_q != IDLE) ? {1'b1, sound_q, oct_q, code_q} : 8'd0;
    end

    // Tone divider: sound starts low and flips after every `half` PLAY cycles.
    // A half-period of 0 marks a rest, so the divider never toggles.
    always_comb begin
        sound_d    = sound_q;
        tone_cnt_d = tone_cnt_q;
        if (accept) begin
            sound_d    = 1'b0;
            tone_cnt_d = (half_in == 8'd0) ? 8'd0 : half_in - 8'd1;
        end else if (state_q == PLAY) begin
            if (ms_end) begin
                sound_d = 1'b0;
            end else if (half_q != 8'd0) begin
                if (tone_cnt_q == 8'd0) begin
                    sound_d    = ~sound_q;
                    tone_cnt_d = half_q - 8'd1;
                end else begin
                    tone_cnt_d = tone_cnt_q - 8'd1;
                end
            end
        end else begin
            sound_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sound_q    <= 1'b0;
            tone_cnt_q <= 8'd0;
        end else begin
            sound_q    <= sound_d;
            tone_cnt_q <= tone_cnt_d;
        end
    end

    // Note parameters are only observed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            code_q <= note_code;
            oct_q  <= note_octave;
            half_q <= half_in;
            tpm_q  <= tpm_in;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed bench for note_player. Two instances share the
// request fields: index 0 with a 10 ms gap, index 1 with no gap. A timeline
// model (cycles elapsed since acceptance) predicts every output each cycle.
module tb_note_player;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] tpm;
    logic [3:0]  code;
    logic [1:0]  oct;
    logic [9:0]  dur;
    logic        vld   [2];
    logic        rdy   [2];
    logic        snd   [2];
    logic        bsy   [2];
    logic [7:0]  led_w [2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    note_player #(.GAP_MS(10), .DUR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm),
        .note_valid(vld[0]), .note_ready(rdy[0]), .note_code(code),
        .note_octave(oct), .note_dur_ms(dur),
        .sound(snd[0]), .busy(bsy[0]), .led(led_w[0])
    );

    note_player #(.GAP_MS(0), .DUR_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm),
        .note_valid(vld[1]), .note_ready(rdy[1]), .note_code(code),
        .note_octave(oct), .note_dur_ms(dur),
        .sound(snd[1]), .busy(bsy[1]), .led(led_w[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a note occupies tot = (dur + gap) * tpm busy cycles; during the
    // first dur*tpm of them the tone level is (k / half) mod 2.
    localparam int GAPS [2] = '{10, 0};
    int   TAB [16] = '{0, 191, 180, 170, 161, 152, 143, 135, 128, 120, 114, 107, 101, 0, 0, 0};
    bit   m_act [2];
    bit   m_rdy [2];
    int   m_k [2], m_play [2], m_tot [2], m_half [2];
    logic [3:0] m_code [2];
    logic [1:0] m_oct  [2];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    int es;
                    int el;
                    int er;
                    if (m_act[i]) begin
                        es = (m_k[i] < m_play[i] && m_half[i] != 0) ? (m_k[i] / m_half[i]) % 2 : 0;
                        el = 128 + es * 64 + int'(m_oct[i]) * 16 + int'(m_code[i]);
                        er = 0;
                    end else begin
                        es = 0;
                        el = 0;
                        er = m_rdy[i] ? 1 : 0;
                    end
                    check($sformatf("sound[%0d]", i), int'(snd[i]), es);
                    check($sformatf("busy[%0d]", i), int'(bsy[i]), m_act[i] ? 1 : 0);
                    check($sformatf("led[%0d]", i), int'(led_w[i]), el);
                    check($sformatf("ready[%0d]", i), int'(rdy[i]), er);
                end
            end
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_act[i] = 1'b0;
                    m_rdy[i] = 1'b0;
                end else if (m_act[i]) begin
                    m_k[i]++;
                    if (m_k[i] >= m_tot[i]) begin
                        m_act[i] = 1'b0;
                        m_rdy[i] = 1'b1;
                    end
                end else if (vld[i] && m_rdy[i]) begin
                    int t;
                    t         = (tpm == 16'd0) ? 1 : int'(tpm);
                    m_code[i] = code;
                    m_oct[i]  = oct;
                    m_half[i] = TAB[code] >> oct;
                    m_play[i] = int'(dur) * t;
                    m_tot[i]  = m_play[i] + GAPS[i] * t;
                    m_k[i]    = 0;
                    m_act[i]  = (m_tot[i] != 0);
                    m_rdy[i]  = !m_act[i];
                end else begin
                    m_rdy[i] = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!rdy[i] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_seen[%0d]", i), int'(rdy[i]), 1);
    endtask

    // Issue one note on instance i and measure its busy window.
    task automatic play_note(input int i, input int c, input int o, input int d, input int t,
                             output int busy_n, output int rise, output int hi_n,
                             output int led_first, output int led_rise);
        @(negedge clk);
        wait_ready(i);
        code   = 4'(c);
        oct    = 2'(o);
        dur    = 10'(d);
        tpm    = 16'(t);
        vld[i] = 1'b1;
        @(negedge clk);
        vld[i]    = 1'b0;
        busy_n    = 0;
        rise      = -1;
        hi_n      = 0;
        led_first = -1;
        led_rise  = -1;
        while (bsy[i] && busy_n < 20000) begin
            if (busy_n == 0) led_first = int'(led_w[i]);
            if (snd[i]) begin
                hi_n++;
                if (rise < 0) begin
                    rise     = busy_n;
                    led_rise = int'(led_w[i]);
                end
            end
            busy_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bn, rs, hn, lf, lr;
        int n1, ng, n2;
        rst_n  = 1'b0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        code   = 4'd0;
        oct    = 2'd0;
        dur    = 10'd0;
        tpm    = 16'd100;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_sound", int'(snd[0]), 0);
        check("rst_busy", int'(bsy[0]), 0);
        check("rst_led", int'(led_w[0]), 0);
        check("rst_ready", int'(rdy[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(rdy[0]), 1);

        // A4, 2 ms at tpm=100
        play_note(0, 10, 0, 2, 100, bn, rs, hn, lf, lr);
        check("a4_busy_len", bn, 1200);
        check("a4_first_rise", rs, 114);
        check("a4_high_cycles", hn, 86);
        check("a4_led_low", lf, 8'h8A);
        check("a4_led_high", lr, 8'hCA);

        // C shifted up two octaves: half = 191 >> 2 = 47
        play_note(0, 1, 2, 1, 100, bn, rs, hn, lf, lr);
        check("oct_busy_len", bn, 1100);
        check("oct_first_rise", rs, 47);
        check("oct_high_cycles", hn, 47);
        check("oct_led_low", lf, 8'hA1);
        check("oct_led_high", lr, 8'hE1);

        // Rest, then zero duration
        play_note(0, 0, 0, 3, 100, bn, rs, hn, lf, lr);
        check("rest_busy_len", bn, 1300);
        check("rest_high_cycles", hn, 0);
        check("rest_led", lf, 8'h80);
        play_note(0, 0, 0, 0, 100, bn, rs, hn, lf, lr);
        check("dur0_busy_len", bn, 1000);
        check("dur0_high_cycles", hn, 0);

        // Back-to-back on the gapless instance
        @(negedge clk);
        wait_ready(1);
        code   = 4'd1;
        oct    = 2'd0;
        dur    = 10'd5;
        tpm    = 16'd1;
        vld[1] = 1'b1;
        @(negedge clk);
        dur = 10'd3;
        n1  = 0;
        while (bsy[1] && n1 < 100) begin n1++; @(negedge clk); end
        ng = 0;
        n2 = 0;
        while (!bsy[1] && n2 < 100) begin
            if (rdy[1]) ng++;
            n2++;
            @(negedge clk);
        end
        vld[1] = 1'b0;
        n2 = 0;
        while (bsy[1] && n2 < 100) begin n2++; @(negedge clk); end
        check("b2b_first_len", n1, 5);
        check("b2b_idle_ready", ng, 1);
        check("b2b_second_len", n2, 3);

        // Reset in the middle of a note
        @(negedge clk);
        wait_ready(0);
        code   = 4'd10;
        oct    = 2'd0;
        dur    = 10'd2;
        tpm    = 16'd100;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (57) @(negedge clk);
        check("pre_rst_busy", int'(bsy[0]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sound", int'(snd[0]), 0);
        check("midrst_busy", int'(bsy[0]), 0);
        check("midrst_led", int'(led_w[0]), 0);
        rst_n = 1'b1;

        // tpm = 0 behaves as 1: 4 PLAY cycles + 10 GAP cycles
        play_note(0, 1, 0, 4, 0, bn, rs, hn, lf, lr);
        check("tpm0_busy_len", bn, 14);
        check("tpm0_high_cycles", hn, 0);
        check("tpm0_led", lf, 8'h81);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
